// File: rtl/turfio_reg_arbiter.sv
// Two-master register-bus arbiter: round-robin grant, optional bus lock with timeout,
// fixed three-cycle IDLE -> ACCESS -> COMPLETE transaction.
module turfio_reg_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_wr_i,
    input  logic [5:0]  m0_addr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_lock_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_req_i,
    input  logic        m1_wr_i,
    input  logic [5:0]  m1_addr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_lock_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        bus_wr_o,
    output logic [5:0]  bus_addr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,

    output logic [1:0]  grant_o,
    output logic        lock_err_o
);

    localparam logic [7:0] LockLast = 8'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StComplete
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic        r_lock;
    logic [7:0]  r_lock_cnt;
    logic        r_lock_err;
    logic        r_bus_wr;
    logic [5:0]  r_bus_addr;
    logic [31:0] r_bus_dat;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic [31:0] r_m0_dat;
    logic [31:0] r_m1_dat;

    state_t      w_state_nxt;
    logic        w_owner_nxt;
    logic        w_last_nxt;
    logic        w_lock_nxt;
    logic [7:0]  w_lock_cnt_nxt;
    logic        w_lock_err_nxt;
    logic        w_bus_wr_nxt;
    logic [5:0]  w_bus_addr_nxt;
    logic [31:0] w_bus_dat_nxt;
    logic        w_m0_ack_nxt;
    logic        w_m1_ack_nxt;
    logic [31:0] w_m0_dat_nxt;
    logic [31:0] w_m1_dat_nxt;

    logic        w_win_valid;
    logic        w_win;
    logic        w_win_wr;
    logic [5:0]  w_win_addr;
    logic [31:0] w_win_dat;
    logic        w_owner_lock;
    logic        w_grant_active;

    // Under lock only the holder is eligible; otherwise ties go to the master not served last.
    always_comb begin
        w_win_valid = 1'b0;
        w_win       = 1'b0;
        if (r_lock) begin
            w_win       = r_owner;
            w_win_valid = r_owner ? m1_req_i : m0_req_i;
        end else if (m0_req_i && m1_req_i) begin
            w_win_valid = 1'b1;
            w_win       = ~r_last;
        end else if (m0_req_i) begin
            w_win_valid = 1'b1;
            w_win       = 1'b0;
        end else if (m1_req_i) begin
            w_win_valid = 1'b1;
            w_win       = 1'b1;
        end
    end

    assign w_win_wr     = w_win ? m1_wr_i   : m0_wr_i;
    assign w_win_addr   = w_win ? m1_addr_i : m0_addr_i;
    assign w_win_dat    = w_win ? m1_dat_i  : m0_dat_i;
    assign w_owner_lock = r_owner ? m1_lock_i : m0_lock_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_lock_nxt     = r_lock;
        w_lock_cnt_nxt = r_lock_cnt;
        w_lock_err_nxt = 1'b0;
        w_bus_wr_nxt   = 1'b0;
        w_bus_addr_nxt = r_bus_addr;
        w_bus_dat_nxt  = r_bus_dat;
        w_m0_ack_nxt   = 1'b0;
        w_m1_ack_nxt   = 1'b0;
        w_m0_dat_nxt   = r_m0_dat;
        w_m1_dat_nxt   = r_m1_dat;

        case (r_state)
            StIdle: begin
                if (w_win_valid) begin
                    w_state_nxt    = StAccess;
                    w_owner_nxt    = w_win;
                    w_last_nxt     = w_win;
                    w_bus_wr_nxt   = w_win_wr;
                    w_bus_addr_nxt = w_win_addr;
                    w_bus_dat_nxt  = w_win_dat;
                end else if (r_lock && !w_owner_lock) begin
                    // Holder is neither requesting nor asking to keep the lock.
                    w_lock_nxt = 1'b0;
                end
            end
            StAccess: begin
                w_state_nxt = StComplete;
                if (r_owner) begin
                    w_m1_dat_nxt = bus_dat_i;
                    w_m1_ack_nxt = 1'b1;
                end else begin
                    w_m0_dat_nxt = bus_dat_i;
                    w_m0_ack_nxt = 1'b1;
                end
            end
            StComplete: begin
                w_state_nxt = StIdle;
                w_lock_nxt  = w_owner_lock;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Timeout overrides any lock decision made this cycle.
        if (r_lock) begin
            if (r_lock_cnt == LockLast) begin
                w_lock_nxt     = 1'b0;
                w_lock_err_nxt = 1'b1;
            end else begin
                w_lock_cnt_nxt = r_lock_cnt + 8'd1;
            end
        end
        if (!w_lock_nxt) begin
            w_lock_cnt_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_lock     <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_lock_err <= 1'b0;
            r_bus_wr   <= 1'b0;
            r_bus_addr <= 6'd0;
            r_bus_dat  <= 32'd0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_dat   <= 32'd0;
            r_m1_dat   <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_lock     <= w_lock_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock_err <= w_lock_err_nxt;
            r_bus_wr   <= w_bus_wr_nxt;
            r_bus_addr <= w_bus_addr_nxt;
            r_bus_dat  <= w_bus_dat_nxt;
            r_m0_ack   <= w_m0_ack_nxt;
            r_m1_ack   <= w_m1_ack_nxt;
            r_m0_dat   <= w_m0_dat_nxt;
            r_m1_dat   <= w_m1_dat_nxt;
        end
    end

    assign w_grant_active = (r_state != StIdle) || r_lock;
    assign grant_o        = !w_grant_active ? 2'b00 : (r_owner ? 2'b10 : 2'b01);

    assign m0_ack_o   = r_m0_ack;
    assign m1_ack_o   = r_m1_ack;
    assign m0_dat_o   = r_m0_dat;
    assign m1_dat_o   = r_m1_dat;
    assign bus_wr_o   = r_bus_wr;
    assign bus_addr_o = r_bus_addr;
    assign bus_dat_o  = r_bus_dat;
    assign lock_err_o = r_lock_err;

endmodule

// File: tb/tb_turfio_reg_arbiter.sv
// Bench for turfio_reg_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model and a behavioural register bank.
module tb_turfio_reg_arbiter;

    localparam int unsigned LT = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [1:0]  lock;
    logic [5:0]  addr [2];
    logic [31:0] wdat [2];

    logic        m0_ack, m1_ack;
    logic [31:0] m0_dat, m1_dat;
    logic        bus_wr;
    logic [5:0]  bus_addr;
    logic [31:0] bus_dat, bus_rdat;
    logic [1:0]  grant;
    logic        lock_err;

    logic [31:0] bank [64];
    assign bus_rdat = bank[bus_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    turfio_reg_arbiter #(.LOCK_TIMEOUT(LT)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_wr_i(wr[0]), .m0_addr_i(addr[0]), .m0_dat_i(wdat[0]),
        .m0_lock_i(lock[0]), .m0_ack_o(m0_ack), .m0_dat_o(m0_dat),
        .m1_req_i(req[1]), .m1_wr_i(wr[1]), .m1_addr_i(addr[1]), .m1_dat_i(wdat[1]),
        .m1_lock_i(lock[1]), .m1_ack_o(m1_ack), .m1_dat_o(m1_dat),
        .bus_wr_o(bus_wr), .bus_addr_o(bus_addr), .bus_dat_o(bus_dat), .bus_dat_i(bus_rdat),
        .grant_o(grant), .lock_err_o(lock_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction with an age, a lock holder with an age.
    bit          md_busy;
    int          md_phase;
    int          md_cur;
    bit          md_wr;
    int          md_last;
    bit          md_locked;
    int          md_lock_m;
    int          md_lock_age;
    bit          md_err;
    logic [5:0]  md_bus_addr;
    logic [31:0] md_bus_dat;
    logic [31:0] md_dat [2];
    logic [31:0] md_mem [64];

    task automatic model_reset();
        md_busy = 0; md_phase = 0; md_cur = 0; md_wr = 0; md_last = 1;
        md_locked = 0; md_lock_m = 0; md_lock_age = 0; md_err = 0;
        md_bus_addr = '0; md_bus_dat = '0; md_dat[0] = '0; md_dat[1] = '0;
    endtask

    task automatic model_step();
        bit forced;
        int win;
        forced = 0;
        win = -1;
        if (md_busy && md_phase == 1) begin
            md_dat[md_cur] = md_mem[md_bus_addr];
            if (md_wr) md_mem[md_bus_addr] = md_bus_dat;
        end
        if (rst) begin
            model_reset();
            return;
        end
        md_err = 0;
        if (md_locked) begin
            md_lock_age++;
            if (md_lock_age >= int'(LT)) forced = 1;
        end
        if (md_busy && md_phase == 1) begin
            md_phase = 2;
        end else if (md_busy) begin
            md_busy = 0;
            md_locked = lock[md_cur];
            md_lock_m = md_cur;
        end else begin
            if (md_locked) begin
                if (req[md_lock_m]) win = md_lock_m;
                else if (!lock[md_lock_m]) md_locked = 0;
            end else if (req[0] && req[1]) win = 1 - md_last;
            else if (req[0]) win = 0;
            else if (req[1]) win = 1;
            if (win >= 0) begin
                md_busy = 1; md_phase = 1; md_cur = win; md_last = win;
                md_wr = wr[win]; md_bus_addr = addr[win]; md_bus_dat = wdat[win];
            end
        end
        if (forced) begin
            md_locked = 0;
            md_err = 1;
        end
        if (!md_locked) md_lock_age = 0;
    endtask

    task automatic check_outputs();
        int own;
        own = md_busy ? md_cur : md_lock_m;
        check_eq("m0_ack", 32'(m0_ack), (md_busy && md_phase == 2 && md_cur == 0) ? 1 : 0);
        check_eq("m1_ack", 32'(m1_ack), (md_busy && md_phase == 2 && md_cur == 1) ? 1 : 0);
        check_eq("bus_wr", 32'(bus_wr), (md_busy && md_phase == 1 && md_wr) ? 1 : 0);
        check_eq("bus_addr", 32'(bus_addr), 32'(md_bus_addr));
        check_eq("bus_dat", bus_dat, md_bus_dat);
        check_eq("grant", 32'(grant), (md_busy || md_locked) ? ((own == 1) ? 2 : 1) : 0);
        check_eq("lock_err", 32'(lock_err), 32'(md_err));
        check_eq("m0_dat", m0_dat, md_dat[0]);
        check_eq("m1_dat", m1_dat, md_dat[1]);
    endtask

    // One clock: model advances on current inputs, bank takes the write just after the edge.
    task automatic step();
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        w = bus_wr; a = bus_addr; d = bus_dat;
        model_step();
        @(posedge clk);
        #1;
        if (w === 1'b1) bank[a] = d;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic new_payload(input int m);
        wr[m]   = 1'($urandom_range(0, 1));
        addr[m] = 6'($urandom_range(0, 7));
        wdat[m] = $urandom;
    endtask

    int ack_m [4];
    int ack_c [4];
    int n_ack, n1, m0_first, m1_third, err_c, m1c;

    initial begin
        for (int i = 0; i < 64; i++) begin
            bank[i] = $urandom;
            md_mem[i] = bank[i];
        end
        rst = 1'b1; req = '0; wr = '0; lock = '0;
        addr[0] = '0; addr[1] = '0; wdat[0] = '0; wdat[1] = '0;
        model_reset();
        @(negedge clk);
        step();
        do_reset();

        // Single write from m0.
        req[0] = 1; wr[0] = 1; addr[0] = 6'h06; wdat[0] = 32'h2;
        step();
        check_eq("w_strobe", 32'(bus_wr), 1);
        check_eq("w_addr", 32'(bus_addr), 32'h06);
        check_eq("w_data", bus_dat, 32'h2);
        step();
        check_eq("w_ack", 32'(m0_ack), 1);
        check_eq("w_strobe_off", 32'(bus_wr), 0);
        req[0] = 0;
        step();

        // Single read from m1.
        bank[0] = 32'h5446494F; md_mem[0] = 32'h5446494F;
        req[1] = 1; wr[1] = 0; addr[1] = 6'h00;
        step();
        check_eq("r_nostrobe", 32'(bus_wr), 0);
        step();
        check_eq("r_ack", 32'(m1_ack), 1);
        check_eq("r_data", m1_dat, 32'h5446494F);
        req[1] = 0;
        step();

        // Round-robin from reset with both requesting.
        do_reset();
        req = 2'b11; wr = 2'b00; lock = 2'b00;
        n_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (n_ack < 4 && m0_ack) begin ack_m[n_ack] = 0; ack_c[n_ack] = c; n_ack++; end
            if (n_ack < 4 && m1_ack) begin ack_m[n_ack] = 1; ack_c[n_ack] = c; n_ack++; end
        end
        check_eq("rr_count", 32'(n_ack), 4);
        for (int k = 0; k < n_ack; k++) begin
            check_eq("rr_order", 32'(ack_m[k]), 32'(k % 2));
            check_eq("rr_cycle", 32'(ack_c[k]), 32'(2 + 3 * k));
        end
        req = 2'b00;
        step();

        // m1 holds a lock for three transactions while m0 waits.
        do_reset();
        req[1] = 1; lock[1] = 1; wr[1] = 1; addr[1] = 6'h03; wdat[1] = $urandom;
        step();
        req[0] = 1; wr[0] = 0; addr[0] = 6'h05;
        n1 = 0; m0_first = -1; m1_third = -1;
        for (int c = 1; c <= 40 && m0_first < 0; c++) begin
            step();
            if (m1_ack) begin
                n1++;
                if (n1 == 3) begin m1_third = c; lock[1] = 0; req[1] = 0; end
            end
            if (m0_ack) begin m0_first = c; req[0] = 0; end
        end
        check_eq("lk_m1_third", 32'(m1_third), 7);
        check_eq("lk_m0_first", 32'(m0_first), 10);
        step();

        // Lock held with no request until the timeout releases it.
        do_reset();
        req[0] = 1; lock[0] = 1; wr[0] = 0; addr[0] = 6'h01;
        step();
        req[1] = 1; wr[1] = 0; addr[1] = 6'h02; lock[1] = 0;
        step();
        check_eq("to_m0_ack", 32'(m0_ack), 1);
        req[0] = 0;
        err_c = -1; m1c = -1;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c <= 8) check_eq("to_grant_locked", 32'(grant), 32'h1);
            if (lock_err && err_c < 0) begin
                err_c = c;
                check_eq("to_grant_released", 32'(grant), 0);
            end
            if (m1_ack && m1c < 0) begin m1c = c; req[1] = 0; end
        end
        check_eq("to_err_cycle", 32'(err_c), 9);
        check_eq("to_m1_ack_cycle", 32'(m1c), 11);
        lock[0] = 0;
        step();

        // Reset during the ACCESS cycle of a write.
        do_reset();
        req[0] = 1; wr[0] = 1; addr[0] = 6'h09; wdat[0] = 32'hA5A5_0001;
        step();
        check_eq("ra_strobe", 32'(bus_wr), 1);
        rst = 1; req[0] = 0;
        step();
        rst = 0;
        check_eq("ra_wr", 32'(bus_wr), 0);
        check_eq("ra_ack", 32'(m0_ack), 0);
        check_eq("ra_addr", 32'(bus_addr), 0);
        check_eq("ra_dat", bus_dat, 0);
        check_eq("ra_grant", 32'(grant), 0);
        check_eq("ra_m0_dat", m0_dat, 0);
        step();
        check_eq("ra_no_late_ack", 32'(m0_ack), 0);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? m0_ack : m1_ack) begin
                    if ($urandom_range(0, 2) == 0) new_payload(m);
                    else req[m] = 0;
                end else if (!req[m] && $urandom_range(0, 2) == 0) begin
                    req[m] = 1;
                    new_payload(m);
                end else if (req[m] && grant[m] && $urandom_range(0, 3) == 0) begin
                    new_payload(m);
                end
                if ($urandom_range(0, 3) == 0) lock[m] = ~lock[m];
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/turfio_reg_arbiter.md
TURFIO_REG_ARBITER -- requirements
Module: turfio_reg_arbiter

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 64, max cycles one master holds a lock before forced release (range 2..255).
REQ-002 clk_i  in  1  sole clock; all logic rising-edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 m0_req_i / m1_req_i  in  1  level request, host (m0) and sequencer (m1).
REQ-005 m0_wr_i / m1_wr_i  in  1  1 = write, 0 = read; valid while req high.
REQ-006 m0_addr_i / m1_addr_i  in  6  register address; valid while req high.
REQ-007 m0_dat_i / m1_dat_i  in  32  write data; valid while req high.
REQ-008 m0_lock_i / m1_lock_i  in  1  keep grant after this transaction.
REQ-009 m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse.
REQ-010 m0_dat_o / m1_dat_o  out  32  read data; valid in the ack cycle, held until the next ack to that master.
REQ-011 bus_wr_o  out  1  register-bank write strobe.
REQ-012 bus_addr_o  out  6  register-bank address.
REQ-013 bus_dat_o  out  32  register-bank write data.
REQ-014 bus_dat_i  in  32  register-bank combinational read data.
REQ-015 grant_o  out  2  one-hot current owner; 00 when idle and unlocked.
REQ-016 lock_err_o  out  1  one-cycle pulse on forced lock release.

Function
REQ-017 FSM states IDLE, ACCESS, COMPLETE; one transaction takes exactly 3 cycles, IDLE -> ACCESS -> COMPLETE -> IDLE.
REQ-018 In IDLE, eligible req sampled; winner's wr/addr/dat registered into bus_wr_o/bus_addr_o/bus_dat_o; next state ACCESS.
REQ-019 ACCESS: bus_addr_o, bus_dat_o stable; bus_wr_o high this cycle only, and only for writes; bus_dat_i latched at the end of the cycle into the owner's m*_dat_o (reads and writes).
REQ-020 COMPLETE: owner's m*_ack_o high for this cycle only; bus_wr_o low.
REQ-021 Latency: req high in IDLE at cycle N -> bus_wr_o/bus_addr_o valid at N+1 -> ack at N+2.
REQ-022 Requester deasserts req in the ack cycle; req still high in the following IDLE cycle is a new transaction.
REQ-023 Round-robin: both requesting and unlocked -> grant master not last granted; last_grant resets to m1 so m0 wins the first tie.
REQ-024 Single requester always granted when no lock held by the other master.
REQ-025 Lock: owner's lock_i high in COMPLETE -> lock set; while set only the owner is eligible in IDLE; other master's req waits, no ack.
REQ-026 Lock clears when owner's lock_i is low in any COMPLETE cycle, or when owner's req and lock_i are both low in IDLE.
REQ-027 Lock counter increments every cycle lock is set; at LOCK_TIMEOUT it clears the lock and pulses lock_err_o one cycle; in-flight transaction completes normally.
REQ-028 grant_o one-hot for owner in ACCESS/COMPLETE and while lock set; 00 otherwise.
REQ-029 bus_addr_o/bus_dat_o hold last values in IDLE; bus_wr_o high only in ACCESS.
REQ-030 Requester input changes during ACCESS/COMPLETE have no effect on the current transaction.
REQ-031 Never more than one ack high in a cycle; never ack without a preceding ACCESS.

Reset
REQ-032 rst_i high -> next cycle state IDLE, grant_o = 00, lock cleared, lock counter 0, last_grant = m1, all ack_o/bus_wr_o/lock_err_o 0, bus_addr_o 0, bus_dat_o 0, m0_dat_o/m1_dat_o 0.
REQ-033 Reset in ACCESS or COMPLETE aborts the transaction: no ack issued, bus_wr_o low the cycle after reset.

Verification
REQ-034 m0 write addr 0x06 data 0x00000002 -> bus_wr_o one cycle at N+1, bus_addr_o 0x06, bus_dat_o 0x00000002, m0_ack_o at N+2.
REQ-035 m1 read addr 0x00 with bus_dat_i 0x5446494F -> m1_ack_o at N+2, m1_dat_o 0x5446494F, bus_wr_o never high.
REQ-036 m0 and m1 request together from reset, held 4 transactions -> grant order m0, m1, m0, m1; each ack 3 cycles apart.
REQ-037 m1 locks, m0 requests continuously, m1 issues 3 locked transactions then drops lock -> m0 no ack until after m1's third ack, then m0 granted.
REQ-038 LOCK_TIMEOUT=8, m0 holds lock_i high with req low -> lock_err_o pulse 8 cycles after lock set, grant_o 00, pending m1 req then served.
REQ-039 rst_i asserted during ACCESS of an m0 write -> no m0_ack_o, bus_wr_o 0 next cycle, all outputs at reset values.
